// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_if
//  Purpose  : Data-memory request/acknowledge bus between the MEM stage and
//             the data memory.
//  Signals  : dmem_req    request, held high until dmem_ack
//             dmem_we     1 = store, 0 = load
//             dmem_addr   word-aligned byte address
//             dmem_be     byte enables
//             dmem_wdata  lane-replicated store data
//             dmem_ack    access complete, dmem_rdata valid in the same cycle
//             dmem_rdata  load word
//  Modports : master (MEM stage), slave (data memory)
//  Revision : 1.0  initial release
// ============================================================================
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MEM stage of a 5-stage RV32I pipeline. Performs LOAD/STORE over
//             a req/ack data bus, stalls upstream while an access is pending
//             and registers the write-back bundle. Other instructions pass
//             through with one cycle of latency.
//  Params   : TIMEOUT  cycles to wait for dmem_ack before a bus error
//                      (0 = wait forever)
//  Ports    : clk, rst                  clock, synchronous active-high reset
//             valid_i, alu_out_i,
//             opcode_i, funct3_i,
//             rd_i, rs2_data_i          EX/MEM register contents
//             stall_o                   combinational upstream hold
//             dmem                      data-memory bus (master side)
//             wb_valid, wb_we, wb_rd,
//             wb_data, exc_code         registered write-back bundle
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] alu_out_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] rs2_data_i,
  output logic        stall_o,
  mem_stage_if.master dmem,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [1:0]  exc_code
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_rd;
  logic [2:0]    r_f3;
  logic [1:0]    r_off;
  logic          r_load;

  logic        w_is_load, w_is_store, w_f3_legal, w_aligned, w_go, w_writes;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Decode of the instruction currently presented by EX/MEM.
  always_comb begin
    w_is_load  = (opcode_i == OPC_LOAD);
    w_is_store = (opcode_i == OPC_STORE);
    if (w_is_load)
      w_f3_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b101);
    else
      w_f3_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);

    w_aligned = 1'b1;
    w_be      = 4'b1111;
    w_wdata   = rs2_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu_out_i[1:0];
        w_wdata = {4{rs2_data_i[7:0]}};
      end
      2'b01: begin
        w_aligned = ~alu_out_i[0];
        w_be      = alu_out_i[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{rs2_data_i[15:0]}};
      end
      2'b10: w_aligned = (alu_out_i[1:0] == 2'b00);
      default: ;
    endcase

    w_go = valid_i & (w_is_load | w_is_store) & w_f3_legal & w_aligned;

    w_writes = (opcode_i == 7'b0110011) || (opcode_i == 7'b0010011) ||
               (opcode_i == 7'b0110111) || (opcode_i == 7'b0010111) ||
               (opcode_i == 7'b1101111) || (opcode_i == 7'b1100111);
  end

  // Lane select and extension of the returned load word, using the funct3 and
  // byte offset captured when the access was launched.
  always_comb begin
    w_byte = dmem.dmem_rdata[8*r_off +: 8];
    w_half = r_off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (r_f3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'b0, w_byte};
      3'b101:  w_load_data = {16'b0, w_half};
      default: w_load_data = dmem.dmem_rdata;
    endcase
  end

  // Low in the ack cycle so the next instruction is accepted right after.
  assign stall_o = ((r_state == S_IDLE) & w_go) | ((r_state == S_ACCESS) & ~dmem.dmem_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_rd            <= '0;
      r_f3            <= '0;
      r_off           <= '0;
      r_load          <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
      wb_valid        <= 1'b0;
      wb_we           <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
      exc_code        <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            if (w_go) begin
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= w_is_store;
              dmem.dmem_addr  <= {alu_out_i[31:2], 2'b00};
              dmem.dmem_be    <= w_be;
              dmem.dmem_wdata <= w_wdata;
              r_rd            <= rd_i;
              r_f3            <= funct3_i;
              r_off           <= alu_out_i[1:0];
              r_load          <= w_is_load;
              r_cnt           <= '0;
              r_state         <= S_ACCESS;
            end else begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_i;
              wb_data  <= alu_out_i;
              if (w_is_load | w_is_store) begin
                // Memory op rejected before reaching the bus.
                wb_we    <= 1'b0;
                exc_code <= w_f3_legal ? 2'b01 : 2'b11;
              end else begin
                wb_we    <= w_writes & (rd_i != 5'd0);
                exc_code <= 2'b00;
              end
            end
          end
        end
        S_ACCESS: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            wb_valid      <= 1'b1;
            wb_rd         <= r_rd;
            wb_we         <= r_load & (r_rd != 5'd0);
            exc_code      <= 2'b00;
            if (r_load)
              wb_data <= w_load_data;
            r_state <= S_IDLE;
          end else if ((TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1))) begin
            dmem.dmem_req <= 1'b0;
            wb_valid      <= 1'b1;
            wb_rd         <= r_rd;
            wb_we         <= 1'b0;
            exc_code      <= 2'b10;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage: directed scenarios followed by
//             random instruction streams, with a behavioural reference model
//             and a per-cycle compare process.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] alu_out = '0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] rs2 = '0;
  logic        stall_o;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  exc_code;

  mem_stage_if mif();

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid), .alu_out_i(alu_out), .opcode_i(opcode),
    .funct3_i(funct3), .rd_i(rd), .rs2_data_i(rs2), .stall_o(stall_o), .dmem(mif),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .exc_code(exc_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          due;
    bit          we;
    logic [4:0]  rd;
    logic [1:0]  exc;
    bit          chk_data;
    logic [31:0] data;
    bit          lit_en;
    logic [31:0] lit;
  } rec_t;

  rec_t q[$];

  bit          en = 1'b0;
  bit          exp_stall = 1'b0;
  bit          exp_req = 1'b0;
  bit          exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_wdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit writes_rd(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67};
  endfunction

  // acc=1: access goes to the bus; otherwise exc is the completion code.
  function automatic void classify(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, output bit acc, output logic [1:0] exc);
    int size;
    bit legal;
    acc = 1'b0;
    exc = 2'b00;
    if (op == 7'h03 || op == 7'h23) begin
      legal = (op == 7'h03) ? (f3 inside {0, 1, 2, 4, 5}) : (f3 inside {0, 1, 2});
      size  = 1 << f3[1:0];
      if (!legal)               exc = 2'b11;
      else if ((a % size) != 0) exc = 2'b01;
      else                      acc = 1'b1;
    end
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (en) begin
      chk("stall_o", 32'(stall_o), 32'(exp_stall));
      chk("dmem_req", 32'(mif.dmem_req), 32'(exp_req));
      if (exp_req) begin
        chk("dmem_addr", mif.dmem_addr, exp_addr);
        chk("dmem_be", 32'(mif.dmem_be), 32'(exp_be));
        chk("dmem_we", 32'(mif.dmem_we), 32'(exp_we));
        if (exp_we) chk("dmem_wdata", mif.dmem_wdata, exp_wdata);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        rec_t r;
        r = q.pop_front();
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("wb_we", 32'(wb_we), 32'(r.we));
        chk("wb_rd", 32'(wb_rd), 32'(r.rd));
        chk("exc_code", 32'(exc_code), 32'(r.exc));
        if (r.chk_data) chk("wb_data", wb_data, r.data);
        if (r.lit_en)   chk("wb_data_literal", wb_data, r.lit);
      end else begin
        chk("wb_valid_quiet", 32'(wb_valid), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge. delay<0 means the memory never acks;
  // rst_at>=0 asserts reset during that access cycle instead of completing.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] r, input logic [31:0] d, input int delay,
                           input int rst_at, input bit use_rdata, input logic [31:0] fixed_rdata,
                           input bit lit_en, input logic [31:0] lit);
    bit          acc;
    logic [1:0]  exc;
    int          size, off, n;
    logic [31:0] rdata;
    rec_t        rec;
    valid = 1'b1; opcode = op; funct3 = f3; alu_out = a; rd = r; rs2 = d;
    classify(op, f3, a, acc, exc);
    rec.rd = r; rec.lit_en = lit_en; rec.lit = lit;
    if (!acc) begin
      exp_stall    = 1'b0;
      rec.due      = cyc + 1;
      rec.exc      = exc;
      rec.we       = (exc == 2'b00) && writes_rd(op) && (r != 5'd0);
      rec.chk_data = !(op == 7'h03 || op == 7'h23);
      rec.data     = a;
      q.push_back(rec);
      @(posedge clk); #1;
    end else begin
      exp_stall = 1'b1;
      @(posedge clk); #1;
      size = 1 << f3[1:0];
      off  = int'(a[1:0]);
      exp_req  = 1'b1;
      exp_we   = (op == 7'h23);
      exp_addr = a & 32'hFFFF_FFFC;
      exp_be   = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = d[8*(i % size) +: 8];
      n = 0;
      while (1) begin
        if (rst_at == n) begin
          rst = 1'b1; exp_stall = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          break;
        end
        if (delay >= 0 && n == delay) begin
          rdata = use_rdata ? fixed_rdata : $urandom;
          mif.dmem_ack = 1'b1; mif.dmem_rdata = rdata;
          exp_stall    = 1'b0;
          rec.due      = cyc + 1;
          rec.exc      = 2'b00;
          rec.we       = (op == 7'h03) && (r != 5'd0);
          rec.chk_data = (op == 7'h03);
          rec.data     = load_val(f3, off, rdata);
          q.push_back(rec);
          @(posedge clk); #1;
          mif.dmem_ack = 1'b0;
          break;
        end
        exp_stall = 1'b1;
        if (delay < 0 && n == TO - 1) begin
          rec.due = cyc + 1; rec.exc = 2'b10; rec.we = 1'b0; rec.chk_data = 1'b0;
          q.push_back(rec);
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
        n++;
      end
      exp_req = 1'b0;
    end
    valid = 1'b0;
    exp_stall = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    int          k, dly;
    logic [6:0]  nonmem [10];
    nonmem = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h0f, 7'h73, 7'h7f};
    mif.dmem_ack = 1'b0;
    mif.dmem_rdata = '0;

    // Reset state
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_exc", 32'(exc_code), 32'd0);
    chk("rst_req", 32'(mif.dmem_req), 32'd0);
    chk("rst_addr", mif.dmem_addr, 32'd0);
    chk("rst_be", 32'(mif.dmem_be), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b1;
    idle(1);

    // Directed scenarios
    run_instr(7'h33, 3'd0, 32'h40, 5'd5, 32'd0, 0, -1, 1'b0, 32'd0, 1'b1, 32'h40);          // ADD
    run_instr(7'h23, 3'd2, 32'h100, 5'd0, 32'hDEADBEEF, 2, -1, 1'b0, 32'd0, 1'b0, 32'd0);   // SW
    run_instr(7'h03, 3'd0, 32'h103, 5'd7, 32'd0, 0, -1, 1'b1, 32'h80123456, 1'b1, 32'hFFFFFF80); // LB
    run_instr(7'h03, 3'd4, 32'h103, 5'd7, 32'd0, 1, -1, 1'b1, 32'h80123456, 1'b1, 32'h00000080); // LBU
    run_instr(7'h03, 3'd1, 32'h101, 5'd3, 32'd0, 0, -1, 1'b0, 32'd0, 1'b0, 32'd0);          // LH misaligned
    run_instr(7'h03, 3'd3, 32'h100, 5'd3, 32'd0, 0, -1, 1'b0, 32'd0, 1'b0, 32'd0);          // illegal funct3
    run_instr(7'h03, 3'd2, 32'h200, 5'd9, 32'd0, -1, -1, 1'b0, 32'd0, 1'b0, 32'd0);         // LW timeout
    idle(1);
    run_instr(7'h03, 3'd2, 32'h204, 5'd9, 32'd0, -1, 3, 1'b0, 32'd0, 1'b0, 32'd0);          // reset mid-access
    idle(2);
    run_instr(7'h03, 3'd2, 32'h300, 5'd0, 32'd0, 0, -1, 1'b1, 32'h12345678, 1'b0, 32'd0);   // LW rd=0
    run_instr(7'h23, 3'd2, 32'h304, 5'd0, 32'h11223344, 0, -1, 1'b0, 32'd0, 1'b0, 32'd0);   // SW
    run_instr(7'h33, 3'd0, 32'h55, 5'd6, 32'd0, 0, -1, 1'b0, 32'd0, 1'b1, 32'h55);          // ADD right after
    run_instr(7'h23, 3'd0, 32'h102, 5'd0, 32'h000000A5, 0, -1, 1'b0, 32'd0, 1'b0, 32'd0);   // SB lane 2
    run_instr(7'h03, 3'd5, 32'h102, 5'd4, 32'd0, 0, -1, 1'b1, 32'hBEEF0000, 1'b1, 32'h0000BEEF); // LHU
    idle(1);

    // Random stream
    for (int t = 0; t < 400; t++) begin
      k = $urandom_range(0, 9);
      a = $urandom;
      if (k < 4) begin
        op = nonmem[$urandom_range(0, 9)];
        f3 = 3'($urandom);
      end else begin
        op = (k < 7) ? 7'h03 : 7'h23;
        f3 = 3'($urandom);
        if ($urandom_range(0, 3) != 0) f3 = (op == 7'h03) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2));
        if (f3 == 3'd3) f3 = 3'd2;
        if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      end
      dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      run_instr(op, f3, a, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                $urandom, dly, -1, 1'b0, 32'd0, 1'b0, 32'd0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    en = 1'b0;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending_wb actual=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
